// File: rtl/icache_pkg.sv
// Shared state type and parameter-derived field widths for the set-associative instruction cache.
package icache_pkg;

   typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} icache_state_t;

   // Counter and way-select fields keep at least one bit so WORDS=1 / WAYS=1 still elaborate.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int boff_w(input int words);
      return $clog2(words);
   endfunction

   function automatic int tag_w(input int sets, input int words);
      return 30 - idx_w(sets) - boff_w(words);
   endfunction

   function automatic int age_w(input int ways);
      return clog2_min1(ways);
   endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one interface.
interface icache_assoc_if;
   // Fetch: while imemREN is held, ihit=1 marks imemload valid in that same cycle.
   // Memory: a word on iload is taken on each rising edge where iREN=1 and iwait=0.
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        iflush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;

   modport slave  (input  imemREN, imemaddr, iflush, iload, iwait,
                   output ihit, imemload, iREN, iaddr);
   modport master (output imemREN, imemaddr, iflush, iload, iwait,
                   input  ihit, imemload, iREN, iaddr);
endinterface

// File: rtl/icache_lru.sv
// Per-set LRU age tracking; reports the oldest way of the queried set.
module icache_lru
   import icache_pkg::*;
#(
   parameter int SETS = 8,
   parameter int WAYS = 2
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic [idx_w(SETS)-1:0]    set_i,
   input  logic                      touch_en_i,
   input  logic [age_w(WAYS)-1:0]    touch_way_i,
   input  logic                      clear_i,
   output logic [age_w(WAYS)-1:0]    victim_lru_o
);
   localparam int AGE_W = age_w(WAYS);

   generate
      if (WAYS == 1) begin : g_direct
         logic unused;
         assign unused       = ^{CLK, nRST, set_i, touch_en_i, touch_way_i, clear_i};
         assign victim_lru_o = '0;
      end else begin : g_lru
         logic [AGE_W-1:0] age_q [SETS][WAYS];
         logic [AGE_W-1:0] cur_age;

         assign cur_age = age_q[set_i][touch_way_i];

         // Ages of one set stay a permutation of 0..WAYS-1; the touched way becomes youngest.
         always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
               for (int s = 0; s < SETS; s++)
                  for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end else if (clear_i) begin
               for (int s = 0; s < SETS; s++)
                  for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end else if (touch_en_i) begin
               for (int w = 0; w < WAYS; w++) begin
                  if (AGE_W'(w) == touch_way_i)   age_q[set_i][w] <= '0;
                  else if (age_q[set_i][w] < cur_age) age_q[set_i][w] <= age_q[set_i][w] + 1'b1;
               end
            end
         end

         always_comb begin
            victim_lru_o = '0;
            for (int w = 0; w < WAYS; w++)
               if (age_q[set_i][w] == AGE_W'(WAYS - 1)) victim_lru_o = AGE_W'(w);
         end
      end
   endgenerate
endmodule

// File: rtl/icache_assoc.sv
// Set-associative, multi-word-block instruction cache with same-cycle hits,
// word-by-word block refill, LRU replacement and a whole-cache flush.
module icache_assoc
   import icache_pkg::*;
#(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic          CLK,
   input  logic          nRST,
   icache_assoc_if.slave bus,
   output icache_state_t dbg_state_o
);
   localparam int IDX_W  = idx_w(SETS);
   localparam int BOFF_W = boff_w(WORDS);
   localparam int CNT_W  = clog2_min1(WORDS);
   localparam int TAG_W  = tag_w(SETS, WORDS);
   localparam int AGE_W  = age_w(WAYS);
   localparam logic [0:0]       S_IDLE    = 1'b0;
   localparam logic [0:0]       S_FILL    = 1'b1;
   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);

   logic [0:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TAG_W-1:0] mtag_q;
   logic [IDX_W-1:0] midx_q;
   logic [SETS-1:0]  valid_q [WAYS];
   logic [TAG_W-1:0] tag_q   [WAYS][SETS];
   logic [31:0]      data_q  [WAYS][SETS][WORDS];
   logic [31:0]      fbuf_q  [WORDS];

   logic [TAG_W-1:0] a_tag;
   logic [IDX_W-1:0] a_idx;
   logic [CNT_W-1:0] a_boff;
   logic             hit, has_inv, fill_done, ihit, iren;
   logic [AGE_W-1:0] hit_way, inv_way, victim, victim_lru;
   logic [31:0]      rdata, fill_addr;

   assign a_tag  = bus.imemaddr[31 -: TAG_W];
   assign a_idx  = bus.imemaddr[2 + BOFF_W +: IDX_W];
   assign a_boff = (WORDS > 1) ? bus.imemaddr[2 +: CNT_W] : '0;

   // Descending scans so the lowest-numbered matching / invalid way wins.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      has_inv = 1'b0;
      inv_way = '0;
      rdata   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
         if (!valid_q[w][midx_q]) begin
            has_inv = 1'b1;
            inv_way = AGE_W'(w);
         end
      end
      for (int w = 0; w < WAYS; w++)
         for (int k = 0; k < WORDS; k++)
            if (AGE_W'(w) == hit_way && CNT_W'(k) == a_boff) rdata = data_q[w][a_idx][k];
   end

   assign victim = has_inv ? inv_way : victim_lru;

   // Flush overrides everything, including completion of the last refill word.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      fill_done = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.imemREN && !hit) begin
               state_d = S_FILL;
               cnt_d   = '0;
            end
         end
         default: begin
            if (!bus.iwait) begin
               if (cnt_q == LAST_WORD) begin
                  fill_done = 1'b1;
                  state_d   = S_IDLE;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
      if (bus.iflush) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         fill_done = 1'b0;
      end
   end

   assign iren      = (state_q == S_FILL);
   assign ihit      = (state_q == S_IDLE) && bus.imemREN && hit && !bus.iflush;
   assign fill_addr = (32'(mtag_q) << (2 + BOFF_W + IDX_W)) | (32'(midx_q) << (2 + BOFF_W))
                    | (32'(cnt_q) << 2);

   assign bus.ihit     = ihit;
   assign bus.imemload = ihit ? rdata : '0;
   assign bus.iREN     = iren;
   assign bus.iaddr    = iren ? fill_addr : '0;
   assign dbg_state_o  = icache_state_t'(state_q);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mtag_q  <= '0;
         midx_q  <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) tag_q[w][s] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == S_IDLE && bus.imemREN && !hit) begin
            mtag_q <= a_tag;
            midx_q <= a_idx;
         end
         if (bus.iflush) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
         end else if (fill_done) begin
            for (int w = 0; w < WAYS; w++)
               if (AGE_W'(w) == victim) begin
                  valid_q[w][midx_q] <= 1'b1;
                  tag_q[w][midx_q]   <= mtag_q;
               end
         end
      end
   end

   // The last word bypasses the fill buffer straight into the victim line.
   always_ff @(posedge CLK) begin
      if (iren && !bus.iwait)
         for (int k = 0; k < WORDS; k++)
            if (CNT_W'(k) == cnt_q) fbuf_q[k] <= bus.iload;
      if (fill_done)
         for (int w = 0; w < WAYS; w++)
            if (AGE_W'(w) == victim)
               for (int k = 0; k < WORDS; k++)
                  data_q[w][midx_q][k] <= (CNT_W'(k) == cnt_q) ? bus.iload : fbuf_q[k];
   end

   icache_lru #(.SETS(SETS), .WAYS(WAYS)) u_lru (
      .CLK          (CLK),
      .nRST         (nRST),
      .set_i        (iren ? midx_q : a_idx),
      .touch_en_i   (ihit || fill_done),
      .touch_way_i  (fill_done ? victim : hit_way),
      .clear_i      (bus.iflush),
      .victim_lru_o (victim_lru)
   );
endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios on the 8x2x2 cache, then random streams on
// 1-way/4-word and 4-way/1-word variants against a behavioural cache model.
module tb_icache_assoc;
   import icache_pkg::*;

   // ---------------- clock / reset ----------------
   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------- shared stimulus and bookkeeping ----------------
   logic        imemREN  = 1'b0;
   logic [31:0] imemaddr = '0;
   logic        iflush   = 1'b0;
   logic        iwait    = 1'b1;
   logic [31:0] iload    = '0;
   int          sel      = 0;
   bit          rand_lat = 1'b0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          last_lat = 0;
   logic [31:0] exp_q[$];
   logic [31:0] addr_log[$];

   icache_assoc_if bus0();
   icache_assoc_if bus1();
   icache_assoc_if bus2();
   icache_state_t  st0, st1, st2;

   assign bus0.imemREN = imemREN && (sel == 0);
   assign bus1.imemREN = imemREN && (sel == 1);
   assign bus2.imemREN = imemREN && (sel == 2);
   assign bus0.iflush  = iflush && (sel == 0);
   assign bus1.iflush  = iflush && (sel == 1);
   assign bus2.iflush  = iflush && (sel == 2);
   assign bus0.imemaddr = imemaddr;
   assign bus1.imemaddr = imemaddr;
   assign bus2.imemaddr = imemaddr;
   assign bus0.iload = iload;
   assign bus1.iload = iload;
   assign bus2.iload = iload;
   assign bus0.iwait = iwait;
   assign bus1.iwait = iwait;
   assign bus2.iwait = iwait;

   icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2)) u_c0 (
      .CLK(CLK), .nRST(nRST), .bus(bus0), .dbg_state_o(st0));
   icache_assoc #(.SETS(8), .WAYS(1), .WORDS(4)) u_c1 (
      .CLK(CLK), .nRST(nRST), .bus(bus1), .dbg_state_o(st1));
   icache_assoc #(.SETS(8), .WAYS(4), .WORDS(1)) u_c2 (
      .CLK(CLK), .nRST(nRST), .bus(bus2), .dbg_state_o(st2));

   logic          ihit_m, iren_m;
   logic [31:0]   load_m, iaddr_m;
   icache_state_t st_m;

   always_comb begin
      case (sel)
         1: begin
            ihit_m = bus1.ihit; iren_m = bus1.iREN; load_m = bus1.imemload;
            iaddr_m = bus1.iaddr; st_m = st1;
         end
         2: begin
            ihit_m = bus2.ihit; iren_m = bus2.iREN; load_m = bus2.imemload;
            iaddr_m = bus2.iaddr; st_m = st2;
         end
         default: begin
            ihit_m = bus0.ihit; iren_m = bus0.iREN; load_m = bus0.imemload;
            iaddr_m = bus0.iaddr; st_m = st0;
         end
      endcase
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[31:2], 2'b00} ^ 32'hC0DE_0000 ^ {a[9:2], 24'h0};
   endfunction

   // ---------------- memory responder ----------------
   int wcnt = 0;
   int wtarget = 2;
   always @(posedge CLK) begin
      #2;
      if (!iren_m) begin
         wcnt  = 0;
         iwait = 1'b1;
      end else if (wcnt >= wtarget) begin
         iwait   = 1'b0;
         iload   = mem_word(iaddr_m);
         wcnt    = 0;
         wtarget = rand_lat ? $urandom_range(0, 2) : 2;
      end else begin
         iwait = 1'b1;
         wcnt++;
      end
   end

   // ---------------- reference model for the random sweep ----------------
   logic [31:0] m_tag [8][4];
   bit          m_val [8][4];
   int          m_age [8][4];

   function automatic void model_reset();
      for (int s = 0; s < 8; s++)
         for (int w = 0; w < 4; w++) begin
            m_val[s][w] = 1'b0;
            m_age[s][w] = w;
         end
   endfunction

   function automatic bit model_access(input logic [31:0] a, input int ways, input int words);
      int bw, idx, hw, v, t, old;
      logic [31:0] tag;
      bw  = (words == 4) ? 2 : 0;
      idx = int'((a >> (2 + bw)) & 32'd7);
      tag = a >> (5 + bw);
      hw  = -1;
      v   = -1;
      for (int w = 0; w < ways; w++)
         if (hw < 0 && m_val[idx][w] && m_tag[idx][w] == tag) hw = w;
      if (hw < 0) begin
         for (int w = 0; w < ways; w++) if (v < 0 && !m_val[idx][w]) v = w;
         if (v < 0) for (int w = 0; w < ways; w++) if (m_age[idx][w] == ways - 1) v = w;
         m_val[idx][v] = 1'b1;
         m_tag[idx][v] = tag;
      end
      t   = (hw >= 0) ? hw : v;
      old = m_age[idx][t];
      for (int w = 0; w < ways; w++) if (m_age[idx][w] < old) m_age[idx][w]++;
      m_age[idx][t] = 0;
      return hw >= 0;
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_log(input string name, input logic [31:0] a0, input logic [31:0] a1);
      check({name, " word count"}, addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         check({name, " iaddr word0"}, addr_log[0], a0);
         check({name, " iaddr word1"}, addr_log[1], a1);
      end
   endtask

   // ---------------- driver tasks (entered and left just after a rising edge) ----------------
   task automatic fetch(input logic [31:0] a, input bit exp_hit, input string name);
      bit got;
      got      = 1'b0;
      last_lat = 0;
      addr_log.delete();
      imemREN  = 1'b1;
      imemaddr = a;
      exp_q.push_back(mem_word(a));
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLK);
         last_lat++;
         if (ihit_m) begin
            got = 1'b1;
            check({name, " iREN at hit"}, 32'(iren_m), 32'd0);
         end else if (iren_m && !iwait) begin
            addr_log.push_back(iaddr_m);
         end
      end
      if (!got) begin
         check({name, " timeout waiting for ihit"}, 32'd0, 32'd1);
         void'(exp_q.pop_back());
      end else begin
         check({name, " hit status"}, 32'(last_lat == 1), 32'(exp_hit));
      end
      @(posedge CLK); #1;
      imemREN = 1'b0;
   endtask

   task automatic flush_pulse();
      iflush = 1'b1;
      @(posedge CLK); #1;
      iflush = 1'b0;
   endtask

   // ---------------- main sequence with scoreboard monitor ----------------
   initial begin
      bit          seen;
      bit          h;
      int          dut_miss, model_miss, ways, words;
      logic [31:0] a;

      fork
         forever begin
            @(negedge CLK);
            if (ihit_m) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected ihit: imemload %h with no fetch outstanding", load_m);
               end else begin
                  check("imemload", load_m, exp_q.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("reset ihit", 32'(ihit_m), 32'd0);
      check("reset iREN", 32'(iren_m), 32'd0);
      check("reset iaddr", iaddr_m, 32'd0);
      check("reset imemload", load_m, 32'd0);
      check("reset state", 32'(st_m), 32'(IDLE));
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Cold miss, two wait cycles per word: latency 1 + 3 + 3 + 1.
      fetch(32'h0000_0040, 1'b0, "cold 0x40");
      check("cold miss latency", last_lat, 8);
      check_log("cold 0x40", 32'h0000_0040, 32'h0000_0044);
      fetch(32'h0000_0044, 1'b1, "word1 0x44");

      // Three blocks in set 0 of a 2-way cache: the oldest is evicted.
      flush_pulse();
      fetch(32'h0000_0000, 1'b0, "conflict 0x000");
      fetch(32'h0000_0040, 1'b0, "conflict 0x040");
      fetch(32'h0000_0080, 1'b0, "conflict 0x080");
      fetch(32'h0000_0040, 1'b1, "conflict 0x040 again");
      fetch(32'h0000_0000, 1'b0, "conflict 0x000 evicted");

      // A hit refreshes A, so C replaces B.
      flush_pulse();
      fetch(32'h0000_0000, 1'b0, "lru A");
      fetch(32'h0000_0040, 1'b0, "lru B");
      fetch(32'h0000_0000, 1'b1, "lru A hit");
      fetch(32'h0000_0080, 1'b0, "lru C");
      fetch(32'h0000_0000, 1'b1, "lru A still");
      fetch(32'h0000_0040, 1'b0, "lru B evicted");

      // Flush while requesting a resident line: no hit that cycle, line gone afterwards.
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0000;
      iflush   = 1'b1;
      @(negedge CLK);
      check("ihit forced low in flush cycle", 32'(ihit_m), 32'd0);
      @(posedge CLK); #1;
      iflush  = 1'b0;
      imemREN = 1'b0;
      fetch(32'h0000_0000, 1'b0, "after idle flush 0x000");

      // Flush after the first refill word aborts the fill.
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0100;
      seen     = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge CLK);
         if (iren_m && !iwait) seen = 1'b1;
      end
      check("flush test first word", 32'(seen), 32'd1);
      @(posedge CLK); #1;
      iflush  = 1'b1;
      imemREN = 1'b0;
      @(posedge CLK); #1;
      iflush = 1'b0;
      @(negedge CLK);
      check("iREN after mid-fill flush", 32'(iren_m), 32'd0);
      check("state after mid-fill flush", 32'(st_m), 32'(IDLE));
      @(posedge CLK); #1;
      fetch(32'h0000_0100, 1'b0, "refetch 0x100");
      check("refetch latency", last_lat, 8);
      check_log("refetch 0x100", 32'h0000_0100, 32'h0000_0104);

      // Asynchronous reset in the middle of a refill.
      imemREN  = 1'b1;
      imemaddr = 32'h0000_01C0;
      repeat (3) @(negedge CLK);
      check("state before reset", 32'(st_m), 32'(FILL));
      #1 nRST = 1'b0;
      #1;
      check("iREN during async reset", 32'(iren_m), 32'd0);
      check("ihit during async reset", 32'(ihit_m), 32'd0);
      check("state during async reset", 32'(st_m), 32'(IDLE));
      imemREN = 1'b0;
      @(posedge CLK); #1;
      nRST = 1'b1;
      @(posedge CLK); #1;
      fetch(32'h0000_0100, 1'b0, "0x100 after reset");

      // Random streams on the other geometries against the model.
      rand_lat = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         sel        = c;
         ways       = (c == 1) ? 1 : 4;
         words      = (c == 1) ? 4 : 1;
         dut_miss   = 0;
         model_miss = 0;
         model_reset();
         @(posedge CLK); #1;
         for (int n = 0; n < 48; n++) begin
            a = 32'($urandom_range(0, 63)) << 2;
            h = model_access(a, ways, words);
            if (!h) model_miss++;
            fetch(a, h, (c == 1) ? "sweep w1x4" : "sweep w4x1");
            if (last_lat > 1) dut_miss++;
         end
         check((c == 1) ? "sweep w1x4 miss count" : "sweep w4x1 miss count", dut_miss, model_miss);
      end

      @(negedge CLK);
      check("scoreboard drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
